// File: rtl/diff_sums.sv
// diff_sums: turns a stream of cumulative sums back into per-bin counts by
// taking the difference of adjacent sums. Frames are BINS tokens long, and the
// first bin of every frame is taken against zero. Malformed streams raise
// sticky flags: a sum smaller than its predecessor, or a bin count too large
// for OUT_W bits. A single output register decouples the two handshakes, and
// In1_ACK is allowed through whenever that register is empty or is draining
// in the same cycle. This keeps one token per cycle at full throughput.
module diff_sums #(
  parameter int BINS  = 256,
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [IN_W-1:0]  In1_DATA,
  input  logic             In1_SEND,
  input  logic [15:0]      In1_COUNT,
  output logic             In1_ACK,
  output logic [OUT_W-1:0] Out1_DATA,
  output logic             Out1_SEND,
  output logic [15:0]      Out1_COUNT,
  input  logic             Out1_RDY,
  input  logic             Out1_ACK,
  output logic             FRAME_DONE,
  output logic             ERR_NONMONO,
  output logic             ERR_OVF
);

  // A frame of one bin still needs a one-bit index so that the counter
  // stays legal. The difference must be wider than the count (IN_W > OUT_W),
  // otherwise the overflow test has no upper bits to look at.
  localparam int IDX_W = (BINS > 1) ? $clog2(BINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BINS - 1);

  // The producer always sends one token per SEND. The count field carries no
  // information, so it is folded into a deliberately unused net.
  logic unusedCount;
  assign unusedCount = ^In1_COUNT;

  logic [IN_W-1:0]  prev_q,   prev_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [OUT_W-1:0] obuf_q,   obuf_d;
  logic             ovalid_q, ovalid_d;
  logic             olast_q,  olast_d;
  logic             errNm_q,  errNm_d;
  logic             errOvf_q, errOvf_d;

  logic             outSend;
  logic             outXfer;
  logic             inAck;
  logic             inXfer;
  logic             isLastBin;
  logic [IN_W-1:0]  base;
  logic [IN_W-1:0]  diff;
  logic             isNonMono;
  logic             isOvf;
  logic [OUT_W-1:0] binCount;

  // Handshake decode: output is offered only when downstream is ready, and the
  // input is taken whenever the buffer is empty or empties this very cycle.
  always_comb begin
    outSend = ovalid_q & Out1_RDY;
    outXfer = outSend & Out1_ACK;
    inAck   = In1_SEND & (~ovalid_q | outXfer);
    inXfer  = inAck;
  end

  // Difference datapath: bin 0 of a frame uses base zero regardless of prev,
  // non-monotonic sums yield zero and oversized differences saturate.
  always_comb begin
    isLastBin = (idx_q == LAST_IDX);
    base      = (idx_q == '0) ? '0 : prev_q;
    diff      = In1_DATA - base;
    isNonMono = (In1_DATA < base);
    isOvf     = |diff[IN_W-1:OUT_W];
    if (isNonMono) begin
      binCount = '0;
    end else if (isOvf) begin
      binCount = '1;
    end else begin
      binCount = diff[OUT_W-1:0];
    end
  end

  // Next-state logic: an accepted token always refills the buffer, which also
  // covers simultaneous drain and refill. A drain alone just empties it.
  always_comb begin
    prev_d   = prev_q;
    idx_d    = idx_q;
    obuf_d   = obuf_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    errNm_d  = errNm_q;
    errOvf_d = errOvf_q;
    if (inXfer) begin
      prev_d   = In1_DATA;
      obuf_d   = binCount;
      ovalid_d = 1'b1;
      olast_d  = isLastBin;
      idx_d    = isLastBin ? '0 : idx_q + IDX_W'(1);
      if (isNonMono) begin
        errNm_d = 1'b1;
      end else if (isOvf) begin
        errOvf_d = 1'b1;
      end
    end else if (outXfer) begin
      ovalid_d = 1'b0;
    end
  end

  // State registers with synchronous reset. A reset mid-frame drops any
  // buffered token and restarts the frame at bin 0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_q   <= '0;
      idx_q    <= '0;
      obuf_q   <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      errNm_q  <= 1'b0;
      errOvf_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      idx_q    <= idx_d;
      obuf_q   <= obuf_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      errNm_q  <= errNm_d;
      errOvf_q <= errOvf_d;
    end
  end

  assign In1_ACK     = inAck;
  assign Out1_DATA   = obuf_q;
  assign Out1_SEND   = outSend;
  assign Out1_COUNT  = 16'h1;
  assign FRAME_DONE  = outXfer & olast_q;
  assign ERR_NONMONO = errNm_q;
  assign ERR_OVF     = errOvf_q;

endmodule

// File: tb/tb_diff_sums.sv
// tb_diff_sums: directed sum sequences with hand-computed bin counts for a
// four-bin build of diff_sums. Stimulus pushes each expected token into a
// scoreboard on acceptance; a monitor pops and compares on every output
// transfer, including frame-done and the sticky error flags.
module tb_diff_sums;

  localparam int BINS  = 4;
  localparam int IN_W  = 32;
  localparam int OUT_W = 16;

  typedef struct {
    logic [OUT_W-1:0] data;
    bit               last;
    bit               nm;
    bit               ovf;
    int               acceptCycle;
    bit               strict;
  } expT;

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic [IN_W-1:0]  In1_DATA = '0;
  logic             In1_SEND = 1'b0;
  logic [15:0]      In1_COUNT = 16'h1;
  logic             In1_ACK;
  logic [OUT_W-1:0] Out1_DATA;
  logic             Out1_SEND;
  logic [15:0]      Out1_COUNT;
  logic             Out1_RDY = 1'b0;
  logic             Out1_ACK = 1'b0;
  logic             FRAME_DONE;
  logic             ERR_NONMONO;
  logic             ERR_OVF;

  int  assertions = 0;
  int  failures = 0;
  int  cycle = 0;
  bit  monitorOn = 1'b0;
  expT sb[$];
  int  doneCycles[$];

  diff_sums #(.BINS(BINS), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .In1_DATA(In1_DATA),
    .In1_SEND(In1_SEND),
    .In1_COUNT(In1_COUNT),
    .In1_ACK(In1_ACK),
    .Out1_DATA(Out1_DATA),
    .Out1_SEND(Out1_SEND),
    .Out1_COUNT(Out1_COUNT),
    .Out1_RDY(Out1_RDY),
    .Out1_ACK(Out1_ACK),
    .FRAME_DONE(FRAME_DONE),
    .ERR_NONMONO(ERR_NONMONO),
    .ERR_OVF(ERR_OVF)
  );

  // Free-running clock, period 10.
  always #5 CLK = ~CLK;

  // Cycle counter used to measure accept-to-output latency.
  always @(posedge CLK) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic pushExpected(input logic [OUT_W-1:0] data, input bit last, input bit nm,
                              input bit ovf, input bit strict);
    expT e;
    e.data = data;
    e.last = last;
    e.nm = nm;
    e.ovf = ovf;
    e.acceptCycle = cycle;
    e.strict = strict;
    sb.push_back(e);
  endtask

  // Offers one sum until it is accepted, recording its expected bin count.
  task automatic applyStimulus(input logic [IN_W-1:0] data, input logic [OUT_W-1:0] expData,
                               input bit expLast, input bit expNm, input bit expOvf,
                               input bit strict);
    bit accepted = 1'b0;
    In1_SEND = 1'b1;
    In1_DATA = data;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge CLK);
      if (In1_ACK) begin
        pushExpected(expData, expLast, expNm, expOvf, strict);
        accepted = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    In1_SEND = 1'b0;
    if (!accepted) begin
      assertions++;
      failures++;
      $display("[TB] FAIL accept_timeout: sum %0d never acked", data);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge CLK);
      #1;
    end
    if (sb.size() != 0) begin
      assertions++;
      failures++;
      $display("[TB] FAIL drain_timeout: %0d tokens still expected", sb.size());
      sb.delete();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    @(negedge CLK);
    checkOutput({tag, "_in_ack"}, In1_ACK, 0);
    checkOutput({tag, "_out_send"}, Out1_SEND, 0);
    checkOutput({tag, "_out_data"}, Out1_DATA, 0);
    checkOutput({tag, "_frame_done"}, FRAME_DONE, 0);
    checkOutput({tag, "_err_nm"}, ERR_NONMONO, 0);
    checkOutput({tag, "_err_ovf"}, ERR_OVF, 0);
    checkOutput({tag, "_out_count"}, Out1_COUNT, 1);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks that
  // FRAME_DONE stays low whenever nothing transfers.
  always @(negedge CLK) begin
    expT e;
    if (monitorOn) begin
      if (Out1_SEND && Out1_ACK) begin
        if (sb.size() == 0) begin
          assertions++;
          failures++;
          $display("[TB] FAIL unexpected_token: got %0h, expected none", Out1_DATA);
        end else begin
          e = sb.pop_front();
          checkOutput("out_data", Out1_DATA, e.data);
          checkOutput("frame_done", FRAME_DONE, e.last);
          checkOutput("err_nm_with_token", ERR_NONMONO, e.nm);
          checkOutput("err_ovf_with_token", ERR_OVF, e.ovf);
          if (e.strict) checkOutput("latency", cycle - e.acceptCycle, 1);
        end
        if (FRAME_DONE) doneCycles.push_back(cycle);
      end else begin
        checkOutput("frame_done_idle", FRAME_DONE, 0);
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    monitorOn = 1'b1;
    checkResetOutputs("reset");

    // Basic frame: 3,3,10,12 -> 3,0,7,2.
    $display("[TB] basic frame");
    Out1_RDY = 1'b1;
    Out1_ACK = 1'b1;
    doneCycles.delete();
    applyStimulus(3, 3, 0, 0, 0, 1);
    applyStimulus(3, 0, 0, 0, 0, 1);
    applyStimulus(10, 7, 0, 0, 0, 1);
    applyStimulus(12, 2, 1, 0, 0, 1);
    waitDrain();
    checkOutput("basic_done_count", doneCycles.size(), 1);
    checkOutput("basic_no_err_nm", ERR_NONMONO, 0);
    checkOutput("basic_no_err_ovf", ERR_OVF, 0);

    // Back-to-back frames: 5,6,6,9 -> 5,1,0,3 then 1,2,3,4 -> 1,1,1,1.
    $display("[TB] back-to-back frames");
    doneCycles.delete();
    applyStimulus(5, 5, 0, 0, 0, 1);
    applyStimulus(6, 1, 0, 0, 0, 1);
    applyStimulus(6, 0, 0, 0, 0, 1);
    applyStimulus(9, 3, 1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 1);
    applyStimulus(2, 1, 0, 0, 0, 1);
    applyStimulus(3, 1, 0, 0, 0, 1);
    applyStimulus(4, 1, 1, 0, 0, 1);
    waitDrain();
    checkOutput("b2b_done_count", doneCycles.size(), 2);
    if (doneCycles.size() == 2) checkOutput("b2b_done_spacing", doneCycles[1] - doneCycles[0], 4);

    // Backpressure: RDY low with ACK high is not a transfer; one token fills.
    $display("[TB] backpressure");
    Out1_RDY = 1'b0;
    Out1_ACK = 1'b1;
    In1_SEND = 1'b1;
    In1_DATA = 100;
    @(negedge CLK);
    checkOutput("bp_first_ack", In1_ACK, 1);
    checkOutput("bp_first_send_low", Out1_SEND, 0);
    pushExpected(100, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    In1_DATA = 150;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("bp_stall_ack", In1_ACK, 0);
      checkOutput("bp_stall_send", Out1_SEND, 0);
      checkOutput("bp_held_data", Out1_DATA, 100);
      @(posedge CLK);
      #1;
    end
    Out1_RDY = 1'b1;
    applyStimulus(150, 50, 0, 0, 0, 1);
    applyStimulus(151, 1, 0, 0, 0, 1);
    applyStimulus(400, 249, 1, 0, 0, 1);
    waitDrain();

    // Errors: 10,7,7,70007 -> 10,0,0,65535 with flags rising alongside.
    $display("[TB] error flags");
    applyStimulus(10, 10, 0, 0, 0, 1);
    applyStimulus(7, 0, 0, 1, 0, 1);
    applyStimulus(7, 0, 0, 1, 0, 1);
    applyStimulus(70007, 16'hFFFF, 1, 1, 1, 1);
    applyStimulus(1, 1, 0, 1, 1, 1);
    applyStimulus(2, 1, 0, 1, 1, 1);
    applyStimulus(3, 1, 0, 1, 1, 1);
    applyStimulus(4, 1, 1, 1, 1, 1);
    waitDrain();
    checkOutput("err_nm_sticky", ERR_NONMONO, 1);
    checkOutput("err_ovf_sticky", ERR_OVF, 1);

    // Reset mid-frame with a token (count 5) still buffered.
    $display("[TB] reset mid-frame");
    applyStimulus(20, 20, 0, 1, 1, 1);
    applyStimulus(25, 5, 0, 1, 1, 1);
    Out1_RDY = 1'b0;
    RESET = 1'b1;
    if (sb.size() != 0) void'(sb.pop_back());
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    Out1_RDY = 1'b1;
    checkResetOutputs("midreset");
    doneCycles.delete();
    applyStimulus(9, 9, 0, 0, 0, 1);
    applyStimulus(10, 1, 0, 0, 0, 1);
    applyStimulus(12, 2, 0, 0, 0, 1);
    applyStimulus(20, 8, 1, 0, 0, 1);
    waitDrain();
    checkOutput("midreset_done_count", doneCycles.size(), 1);

    repeat (2) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/diff_sums.md
# diff_sums

Inverse of the prefix-sum stage of the histogram pipeline: consumes a stream of 32-bit cumulative sums and emits 16-bit per-bin counts by adjacent difference (bin k = S[k] − S[k−1], with S[−1] = 0). Frames are BINS tokens long. It sits on the receiving end of a prefix-sum actor's Out1 port and feeds histogram consumers or checkers. It also flags malformed streams: non-monotonic sums and per-bin counts that overflow 16 bits.

## Interface
- BINS, 256: tokens per frame; the index counter wraps after BINS−1.
- IN_W, 32: cumulative-sum width.
- OUT_W, 16: bin-count width.
- CLK  in  1  single clock, rising edge.
- RESET  in  1  synchronous, active-high.
- In1_DATA  in  IN_W  cumulative sum S[k].
- In1_SEND  in  1  producer has a token on In1_DATA.
- In1_COUNT  in  16  ignored; always 1 from the producer.
- In1_ACK  out  1  token consumed this cycle.
- Out1_DATA  out  OUT_W  bin count.
- Out1_SEND  out  1  token valid on Out1_DATA.
- Out1_COUNT  out  16  constant 16'h1.
- Out1_RDY  in  1  downstream can be offered a token.
- Out1_ACK  in  1  downstream takes the token this cycle.
- FRAME_DONE  out  1  one-cycle pulse when bin BINS−1 transfers on Out1.
- ERR_NONMONO  out  1  sticky; S[k] < S[k−1] seen.
- ERR_OVF  out  1  sticky; a difference exceeded 2^OUT_W−1.

## Operation
- State:
  - prev (IN_W)
  - idx (log2 BINS)
  - one-entry output register: obuf (OUT_W), ovalid, olast
  - err_nm, err_ovf
- Transfer rules:
  - Input transfer: In1_SEND & In1_ACK.
  - Output transfer: Out1_SEND & Out1_ACK.
  - Out1_SEND = ovalid & Out1_RDY.
  - In1_ACK = In1_SEND & (~ovalid | (Out1_SEND & Out1_ACK)). This gives full throughput: one token per cycle when downstream acks every cycle.
- On input transfer, with base = (idx==0) ? 0 : prev and d = In1_DATA − base in IN_W bits:
  - In1_DATA < base: obuf ← 0, err_nm ← 1.
  - Else if d > 2^OUT_W−1: obuf ← all ones (saturate), err_ovf ← 1.
  - Else: obuf ← d[OUT_W−1:0].
  - In all cases:
    - prev ← In1_DATA, so the next difference is always taken against the actual previous sum, even on error.
    - ovalid ← 1; olast ← (idx==BINS−1).
    - idx ← (idx==BINS−1) ? 0 : idx+1.
- On output transfer with no simultaneous input transfer: ovalid ← 0.
- On simultaneous output and input transfer: ovalid stays 1 and obuf and olast take the new token.
- FRAME_DONE = Out1_SEND & Out1_ACK & olast.
- The error flags stay set until RESET. They do not clear at frame boundaries.
- Out1_DATA = obuf at all times. Its content is don't-care while ovalid=0, but it must not be X after reset.

## Timing
- Reset: prev=0, idx=0, obuf=0, ovalid=0, olast=0, err_nm=0, err_ovf=0. Resulting outputs: In1_ACK=0, Out1_SEND=0, Out1_DATA=0, FRAME_DONE=0, ERR_*=0, Out1_COUNT=1.
- RESET mid-frame discards any buffered token. The next accepted input is treated as bin 0.
- Latency: a token accepted in cycle t appears on Out1_SEND in cycle t+1, provided Out1_RDY=1.
- Error flags rise in cycle t+1, together with the offending token.
- Out1_RDY low: the token is held and Out1_SEND is 0. Input stalls once the buffer is full.
- Out1_ACK without Out1_SEND has no effect.
- Out1_RDY low while Out1_ACK is high is not a transfer.
- In1_ACK depends combinationally on Out1_ACK and Out1_RDY. No combinational path exists from In1_DATA to any output.
- Frame wrap: the token after bin BINS−1 uses base=0, regardless of prev.

## Test plan
- Basic frame (BINS=4): sums 3,3,10,12 with RDY=ACK=1 throughout.
  - Out1 = 3,0,7,2 at cycles t+1..t+4.
  - FRAME_DONE high only in the cycle that carries 2.
  - No error flags.
- Back-to-back frames: 5,6,6,9 then 1,2,3,4.
  - Second frame outputs 1,1,1,1, so the first bin of a frame uses base 0.
  - Two FRAME_DONE pulses, 4 cycles apart.
- Backpressure:
  - Hold Out1_RDY=0 for 3 cycles with In1_SEND=1: exactly one input is acked and Out1_SEND stays 0.
  - Raise RDY and ACK: tokens drain in order with one token per cycle, none dropped and none duplicated.
- Errors:
  - Sums 10 then 7: output 10 then 0, ERR_NONMONO rises with the second token.
  - Then sums 7 and 70007 (BINS≥4): outputs 0 and 65535 (saturated), ERR_OVF=1.
  - Both flags remain set through the next frame.
- Reset mid-frame:
  - Accept 2 tokens, then pulse RESET with a token buffered.
  - All outputs return to their reset values next cycle.
  - The next sum, 9, outputs 9 (treated as bin 0).
  - FRAME_DONE fires after BINS further tokens.
